// File: rtl/mmu_loader.sv
// Byte-stream loader and sequencer for the 2x2 systolic matrix multiplier.
// Optional macro MMU_LOADER_REUSE_B_EN: keep_b skips LOAD_B to reuse B_flat.
module mmu_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [31:0] A_flat,
    output logic [31:0] B_flat,
    output logic        mmu_rst,
    input  logic        mmu_done,
    output logic        job_done,
    output logic        busy,
    output logic        err,
    input  logic        keep_b
);

    typedef enum logic [1:0] {
        S_LOAD_A,
        S_LOAD_B,
        S_START,
        S_WAIT
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        mmu_rst_q, mmu_rst_d;
    logic        job_done_q, job_done_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic        accept;
    logic        last_byte;
    logic        skip_b;

`ifdef MMU_LOADER_REUSE_B_EN
    assign skip_b = keep_b;
`else
    logic unused_keep_b;
    assign unused_keep_b = keep_b;
    assign skip_b = 1'b0;
`endif

    assign in_ready  = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
    assign accept    = in_valid && in_ready;
    assign last_byte = (idx_q == 2'd3);

    // Next-state, byte packing, wait counter and registered output decode
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        err_d      = err_q;
        job_done_d = 1'b0;
        unique case (state_q)
            S_LOAD_A: begin
                if (accept) begin
                    a_d[{idx_q, 3'b000} +: 8] = in_data;
                    idx_d = idx_q + 2'd1;
                    if (last_byte) begin
                        state_d = skip_b ? S_START : S_LOAD_B;
                    end
                end
            end
            S_LOAD_B: begin
                if (accept) begin
                    b_d[{idx_q, 3'b000} +: 8] = in_data;
                    idx_d = idx_q + 2'd1;
                    if (last_byte) begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                // done outranks a coincident timeout
                if (mmu_done && (cnt_q >= 8'd2)) begin
                    job_done_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_LOAD_A;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_LOAD_A;
                end
            end
            default: begin
                state_d = S_LOAD_A;
            end
        endcase
        mmu_rst_d = (state_d != S_WAIT);
        busy_d    = (state_d == S_START) || (state_d == S_WAIT);
    end

    // State and registered outputs, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_LOAD_A;
            idx_q      <= '0;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            mmu_rst_q  <= 1'b1;
            job_done_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            mmu_rst_q  <= mmu_rst_d;
            job_done_q <= job_done_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign A_flat   = a_q;
    assign B_flat   = b_q;
    assign mmu_rst  = mmu_rst_q;
    assign job_done = job_done_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule
